// File: rtl/hack_mem_pkg.sv
// Shared constants and grant encoding for the Hack data-memory arbiter.
package hack_mem_pkg;

  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned SCREEN_BASE  = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;
  localparam int unsigned KBD_ADDR     = 24576;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_KBD,
    GNT_VID
  } grant_t;

endpackage

// File: rtl/hack_screen_scanner.sv
// Screen scanner: walks the frame buffer one word per grant and holds each
// word on the video port until the sink takes it.
module hack_screen_scanner
  import hack_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_en,
  input  logic              vid_ready,
  input  logic              vid_gnt,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] scan_ptr,
  output logic              vid_want,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_sof
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(SCREEN_BASE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SCREEN_BASE + SCREEN_WORDS - 1);

  // Only fetch when the output slot is free or being drained this cycle.
  always_comb begin
    vid_want = vid_en & (~vid_valid | vid_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_ptr  <= FIRST;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      vid_sof   <= 1'b0;
    end else if (vid_gnt) begin
      vid_data  <= mem_out;
      vid_valid <= 1'b1;
      vid_sof   <= (scan_ptr == FIRST);
      scan_ptr  <= (scan_ptr == LAST) ? FIRST : scan_ptr + 1'b1;
    end else if (vid_valid && vid_ready) begin
      vid_valid <= 1'b0;
      vid_sof   <= 1'b0;
    end
  end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Single-port arbiter sharing Hack data memory between the CPU data port,
// a keyboard injector and the screen scanner.
module hack_mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              kbd_strobe,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              vid_en,
  input  logic              vid_ready,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_sof,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  grant_t              grant;
  grant_t              last_grant;
  logic                kbd_pend;
  logic [DATA_W-1:0]   kbd_q;
  logic [STARVE_W-1:0] starve;
  logic                cpu_want;
  logic                vid_want;
  logic [ADDR_W-1:0]   scan_ptr;

  hack_screen_scanner u_scanner (
    .clk       (clk),
    .reset     (reset),
    .vid_en    (vid_en),
    .vid_ready (vid_ready),
    .vid_gnt   (grant == GNT_VID),
    .mem_out   (mem_out),
    .scan_ptr  (scan_ptr),
    .vid_want  (vid_want),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .vid_sof   (vid_sof)
  );

  // The ack cycle is the one right after a CPU grant; requests are ignored then.
  assign cpu_ack  = (last_grant == GNT_CPU);
  assign cpu_want = cpu_req & ~cpu_ack;

  // Starved video pre-empts everything; otherwise KBD > CPU > VID.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (vid_want && starve == STARVE_W'(STARVE_MAX)) grant = GNT_VID;
      else if (kbd_pend)                              grant = GNT_KBD;
      else if (cpu_want)                              grant = GNT_CPU;
      else if (vid_want)                              grant = GNT_VID;
    end
  end

  always_comb begin
    mem_address = '0;
    mem_load    = 1'b0;
    mem_in      = '0;
    case (grant)
      GNT_CPU: begin
        mem_address = cpu_addr;
        mem_load    = cpu_we;
        mem_in      = cpu_we ? cpu_wdata : '0;
      end
      GNT_KBD: begin
        mem_address = ADDR_W'(KBD_ADDR);
        mem_load    = 1'b1;
        mem_in      = kbd_q;
      end
      GNT_VID: mem_address = scan_ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_NONE;
      kbd_pend   <= 1'b0;
      kbd_q      <= '0;
      starve     <= '0;
      cpu_rdata  <= '0;
    end else begin
      last_grant <= grant;
      // A strobe always lands in the slot, even while the old code is being written.
      if (kbd_strobe) begin
        kbd_pend <= 1'b1;
        kbd_q    <= kbd_code;
      end else if (grant == GNT_KBD) begin
        kbd_pend <= 1'b0;
      end
      if (vid_want && grant != GNT_VID)
        starve <= (starve == STARVE_W'(STARVE_MAX)) ? starve : starve + 1'b1;
      else
        starve <= '0;
      if (grant == GNT_CPU)
        cpu_rdata <= cpu_we ? '0 : mem_out;
    end
  end

endmodule
